// File: rtl/preif_stage_pkg.sv
// Shared definitions for the pre-IF stage.
//   PF_TO_FS_BUS_WD : width of the pre-IF -> IF hand-off bus
//   EXC_CODE_*      : fetch exception codes carried on the bus
//   PC_RESET_DEFAULT: first fetch address after reset
//   pf_bus_t        : field layout of the pre-IF -> IF bus
//   is_unmapped     : true for kseg0/kseg1 (direct-mapped) addresses
package preif_stage_pkg;

    localparam int          PF_TO_FS_BUS_WD  = 71;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'hbfc0_0000;
    localparam logic [4:0]  EXC_CODE_ADEL    = 5'h04;
    localparam logic [4:0]  EXC_CODE_TLBL    = 5'h02;
    localparam logic [4:0]  EXC_CODE_NONE    = 5'h00;

    typedef struct packed {
        logic        tlb_refill;
        logic [31:0] badvaddr;
        logic        has_ex;
        logic [4:0]  ex_type;
        logic [31:0] pc;
    } pf_bus_t;

    function automatic logic is_unmapped(input logic [31:0] vaddr);
        return vaddr[31:30] == 2'b10;
    endfunction

endpackage

// File: rtl/preif_addr_xlate.sv
// Combinational fetch-address translation.
//   vaddr      in   virtual fetch address
//   tlb_found  in   TLB hit
//   tlb_v      in   TLB entry valid bit
//   tlb_pfn    in   TLB physical frame number
//   paddr      out  physical address
//   has_ex     out  fetch raises an exception
//   ex_type    out  exception code (0 when none)
//   tlb_refill out  TLB exception is a refill (miss) rather than invalid
module preif_addr_xlate
    import preif_stage_pkg::*;
#(
    parameter logic [4:0] EXC_ADEL = EXC_CODE_ADEL,
    parameter logic [4:0] EXC_TLBL = EXC_CODE_TLBL
) (
    input  logic [31:0] vaddr,
    input  logic        tlb_found,
    input  logic        tlb_v,
    input  logic [19:0] tlb_pfn,
    output logic [31:0] paddr,
    output logic        has_ex,
    output logic [4:0]  ex_type,
    output logic        tlb_refill
);

    always_comb begin
        paddr      = {tlb_pfn, vaddr[11:0]};
        has_ex     = 1'b0;
        ex_type    = EXC_CODE_NONE;
        tlb_refill = 1'b0;

        if (is_unmapped(vaddr)) begin
            paddr = {3'b000, vaddr[28:0]};
        end

        // Misalignment masks any TLB fault on the same address.
        if (vaddr[1:0] != 2'b00) begin
            has_ex  = 1'b1;
            ex_type = EXC_ADEL;
        end else if (!is_unmapped(vaddr) && !(tlb_found && tlb_v)) begin
            has_ex     = 1'b1;
            ex_type    = EXC_TLBL;
            tlb_refill = !tlb_found;
        end
    end

endmodule

// File: rtl/preif_stage.sv
// Pre-IF stage: owns the fetch PC, picks the next fetch address, translates
// it and issues one I-cache request per instruction; hands {pc, exception
// info} to if_stage.
//   clk, reset                 clock, async active-high reset
//   br_valid/br_target         ID redirect pulse and target
//   br_stall                   ID branch unresolved, hold issue
//   fs_ex/ex_target            exception flush pulse and entry PC
//   fs_cancel_in/cancel_target eret/refetch flush pulse and PC
//   fs_allowin                 if_stage can accept
//   to_fs_valid/preif_to_fs_bus hand-off to if_stage
//   tlb_vaddr/tlb_found/tlb_v/tlb_pfn  TLB lookup
//   inst_cache_valid/addr/addr_ok      I-cache request handshake
module preif_stage
    import preif_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
    parameter logic [4:0]  EXC_ADEL = EXC_CODE_ADEL,
    parameter logic [4:0]  EXC_TLBL = EXC_CODE_TLBL
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       br_valid,
    input  logic [31:0]                br_target,
    input  logic                       br_stall,
    input  logic                       fs_ex,
    input  logic [31:0]                ex_target,
    input  logic                       fs_cancel_in,
    input  logic [31:0]                cancel_target,
    input  logic                       fs_allowin,
    output logic                       to_fs_valid,
    output logic [PF_TO_FS_BUS_WD-1:0] preif_to_fs_bus,
    output logic [31:0]                tlb_vaddr,
    input  logic                       tlb_found,
    input  logic                       tlb_v,
    input  logic [19:0]                tlb_pfn,
    output logic                       inst_cache_valid,
    output logic [31:0]                inst_cache_addr,
    input  logic                       inst_cache_addr_ok
);

    logic [31:0] pc;
    logic [31:0] pend_target;
    logic        br_pend;
    logic        reset_state;
    logic        ex_sent;
    logic [31:0] fetch_addr;
    logic [31:0] paddr;
    logic        has_ex;
    logic [4:0]  ex_type;
    logic        tlb_refill;
    logic        flush;
    logic        issue_ok;
    logic        ex_accept;
    pf_bus_t     bus;

    assign flush = fs_ex | fs_cancel_in;

    always_comb begin
        fetch_addr = pc;
        if (fs_ex)             fetch_addr = ex_target;
        else if (fs_cancel_in) fetch_addr = cancel_target;
        else if (br_valid)     fetch_addr = br_target;
        else if (br_pend)      fetch_addr = pend_target;
    end

    preif_addr_xlate #(
        .EXC_ADEL (EXC_ADEL),
        .EXC_TLBL (EXC_TLBL)
    ) u_xlate (
        .vaddr      (fetch_addr),
        .tlb_found  (tlb_found),
        .tlb_v      (tlb_v),
        .tlb_pfn    (tlb_pfn),
        .paddr      (paddr),
        .has_ex     (has_ex),
        .ex_type    (ex_type),
        .tlb_refill (tlb_refill)
    );

    // reset_state is set asynchronously, so it also masks requests while
    // reset is held and for the first cycle after release.
    assign issue_ok         = ~reset_state & ~flush & ~br_stall & fs_allowin;
    assign inst_cache_valid = issue_ok & ~has_ex;
    assign inst_cache_addr  = paddr;
    assign tlb_vaddr        = fetch_addr;

    // An excepting PC goes to if_stage once, without a cache request.
    assign ex_accept   = issue_ok & has_ex & ~ex_sent;
    assign to_fs_valid = (inst_cache_valid & inst_cache_addr_ok) | ex_accept;

    always_comb begin
        bus.tlb_refill = tlb_refill;
        bus.badvaddr   = has_ex ? fetch_addr : 32'h0;
        bus.has_ex     = has_ex;
        bus.ex_type    = ex_type;
        bus.pc         = fetch_addr;
    end
    assign preif_to_fs_bus = bus;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) reset_state <= 1'b1;
        else       reset_state <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            br_pend     <= 1'b0;
            pend_target <= 32'h0;
            ex_sent     <= 1'b0;
        end else if (flush) begin
            pc      <= fetch_addr;
            br_pend <= 1'b0;
            ex_sent <= 1'b0;
        end else if (to_fs_valid) begin
            // The excepting PC is parked in pc until WB flushes.
            pc      <= has_ex ? fetch_addr : fetch_addr + 32'd4;
            br_pend <= 1'b0;
            ex_sent <= has_ex;
        end else if (br_valid) begin
            br_pend     <= 1'b1;
            pend_target <= br_target;
        end
    end

endmodule

// File: tb/tb_preif_stage.sv
module tb_preif_stage;

    logic        clk;
    logic        reset;
    logic        br_valid;
    logic [31:0] br_target;
    logic        br_stall;
    logic        fs_ex;
    logic [31:0] ex_target;
    logic        fs_cancel_in;
    logic [31:0] cancel_target;
    logic        fs_allowin;
    logic        to_fs_valid;
    logic [70:0] bus;
    logic [31:0] tlb_vaddr;
    logic        tlb_found;
    logic        tlb_v;
    logic [19:0] tlb_pfn;
    logic        inst_cache_valid;
    logic [31:0] inst_cache_addr;
    logic        inst_cache_addr_ok;

    int checks_total  = 0;
    int checks_passed = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_tgt;
    logic        m_rst;
    logic        m_ex_sent;

    preif_stage dut (
        .clk                (clk),
        .reset              (reset),
        .br_valid           (br_valid),
        .br_target          (br_target),
        .br_stall           (br_stall),
        .fs_ex              (fs_ex),
        .ex_target          (ex_target),
        .fs_cancel_in       (fs_cancel_in),
        .cancel_target      (cancel_target),
        .fs_allowin         (fs_allowin),
        .to_fs_valid        (to_fs_valid),
        .preif_to_fs_bus    (bus),
        .tlb_vaddr          (tlb_vaddr),
        .tlb_found          (tlb_found),
        .tlb_v              (tlb_v),
        .tlb_pfn            (tlb_pfn),
        .inst_cache_valid   (inst_cache_valid),
        .inst_cache_addr    (inst_cache_addr),
        .inst_cache_addr_ok (inst_cache_addr_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Address translation as read from the architecture rules.
    function automatic void xlate(input logic [31:0] va, input logic found, input logic v,
                                  input logic [19:0] pfn, output logic [31:0] pa,
                                  output logic hx, output logic [4:0] et, output logic rf);
        hx = 1'b0; et = 5'h00; rf = 1'b0;
        if (va % 4 != 0) begin
            hx = 1'b1; et = 5'h04;
        end
        if (va >= 32'h8000_0000 && va < 32'ha000_0000) pa = va - 32'h8000_0000;
        else if (va >= 32'ha000_0000 && va < 32'hc000_0000) pa = va - 32'ha000_0000;
        else begin
            pa = {12'h000, pfn} * 32'd4096 + (va % 32'd4096);
            if (!hx && !(found && v)) begin
                hx = 1'b1; et = 5'h02; rf = !found;
            end
        end
    endfunction

    task automatic model_reset();
        m_pc = 32'hbfc0_0000; m_pend = 1'b0; m_tgt = 32'h0; m_rst = 1'b1; m_ex_sent = 1'b0;
    endtask

    task automatic idle();
        br_valid = 0; br_target = 32'h0; br_stall = 0; fs_ex = 0; ex_target = 32'h0;
        fs_cancel_in = 0; cancel_target = 32'h0; fs_allowin = 1; inst_cache_addr_ok = 1;
        tlb_found = 1; tlb_v = 1; tlb_pfn = 20'h0;
    endtask

    // Called just after a falling edge with inputs already driven: checks
    // outputs against the model, advances the model over the rising edge,
    // and returns at the next falling edge.
    task automatic step(input string tag);
        logic [31:0] fa, pa;
        logic        hx, rf, fl, e_valid, e_to_fs;
        logic [4:0]  et;
        #1;
        if (fs_ex) fa = ex_target;
        else if (fs_cancel_in) fa = cancel_target;
        else if (br_valid) fa = br_target;
        else if (m_pend) fa = m_tgt;
        else fa = m_pc;
        xlate(fa, tlb_found, tlb_v, tlb_pfn, pa, hx, et, rf);
        fl      = fs_ex | fs_cancel_in;
        e_valid = !m_rst && !fl && !br_stall && fs_allowin && !hx;
        e_to_fs = (e_valid && inst_cache_addr_ok) ||
                  (hx && fs_allowin && !fl && !br_stall && !m_rst && !m_ex_sent);
        chk({tag, ".to_fs_valid"}, 71'(to_fs_valid), 71'(e_to_fs));
        chk({tag, ".icache_valid"}, 71'(inst_cache_valid), 71'(e_valid));
        chk({tag, ".tlb_vaddr"}, 71'(tlb_vaddr), 71'(fa));
        chk({tag, ".bus"}, bus, {rf, (hx ? fa : 32'h0), hx, et, fa});
        if (e_valid) chk({tag, ".icache_addr"}, 71'(inst_cache_addr), 71'(pa));
        @(posedge clk);
        m_rst = 1'b0;
        if (fl) begin
            m_pc = fa; m_pend = 1'b0; m_ex_sent = 1'b0;
        end else if (e_to_fs) begin
            m_pc = hx ? fa : fa + 32'd4; m_pend = 1'b0; m_ex_sent = hx;
        end else if (br_valid) begin
            m_pend = 1'b1; m_tgt = br_target;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        int          k = $urandom_range(0, 19);
        logic [31:0] a = $urandom;
        if (k < 11) return {3'b101, a[28:2], 2'b00} ^ {2'b00, a[29], 29'h0};
        if (k < 16) return {1'b0, a[30:2], 2'b00};
        return a;
    endfunction

    initial begin
        idle();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst.to_fs_valid", 71'(to_fs_valid), 71'(0));
        chk("rst.icache_valid", 71'(inst_cache_valid), 71'(0));
        @(negedge clk);
        reset = 1'b0;

        // first cycle after release drops its request
        #1 chk("rel.icache_valid", 71'(inst_cache_valid), 71'(0));
        step("rel");
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("seq.addr", 71'(inst_cache_addr), 71'(32'h1fc0_0000 + 32'(i) * 4));
            chk("seq.bus_pc", 71'(bus[31:0]), 71'(32'hbfc0_0000 + 32'(i) * 4));
            step("seq");
        end
        step("to10");

        // addr_ok held low at bfc00010
        inst_cache_addr_ok = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait.addr", 71'(inst_cache_addr), 71'(32'h1fc0_0010));
            chk("wait.to_fs", 71'(to_fs_valid), 71'(0));
            step("wait");
        end
        inst_cache_addr_ok = 1;
        #1 chk("wait.accept", 71'(to_fs_valid), 71'(1));
        step("wait_acc");
        #1 chk("wait.next_pc", 71'(tlb_vaddr), 71'(32'hbfc0_0014));

        // branch during stall becomes pending
        br_stall = 1; br_valid = 1; br_target = 32'hbfc0_0100;
        step("brs");
        br_valid = 0;
        #1 chk("brs.pend_addr", 71'(tlb_vaddr), 71'(32'hbfc0_0100));
        step("brs_hold");
        br_stall = 0;
        #1 chk("brs.addr0", 71'(inst_cache_addr), 71'(32'h1fc0_0100));
        step("brs_acc0");
        #1 chk("brs.addr1", 71'(inst_cache_addr), 71'(32'h1fc0_0104));
        step("brs_acc1");

        // exception flush while a request and a branch are pending
        inst_cache_addr_ok = 0; br_valid = 1; br_target = 32'hbfc0_0200;
        step("exf_pend");
        br_valid = 0;
        step("exf_wait");
        fs_ex = 1; ex_target = 32'hbfc0_0380; inst_cache_addr_ok = 1;
        #1 chk("exf.valid", 71'(inst_cache_valid), 71'(0));
        step("exf");
        fs_ex = 0;
        #1 chk("exf.addr", 71'(inst_cache_addr), 71'(32'h1fc0_0380));
        step("exf_acc");
        #1 chk("exf.pend_clr", 71'(tlb_vaddr), 71'(32'hbfc0_0384));
        step("exf_next");

        // refetch to a misaligned PC
        fs_cancel_in = 1; cancel_target = 32'h0040_0002;
        step("cxl");
        fs_cancel_in = 0;
        #1;
        chk("adel.to_fs", 71'(to_fs_valid), 71'(1));
        chk("adel.icache_valid", 71'(inst_cache_valid), 71'(0));
        chk("adel.has_ex", 71'(bus[37]), 71'(1));
        chk("adel.ex_type", 71'(bus[36:32]), 71'(5'h04));
        chk("adel.badvaddr", 71'(bus[69:38]), 71'(32'h0040_0002));
        step("adel");
        #1;
        chk("adel.no_resend", 71'(to_fs_valid), 71'(0));
        chk("adel.pc_frozen", 71'(tlb_vaddr), 71'(32'h0040_0002));
        step("adel_hold");

        // mapped fetch: TLB miss, invalid, hit
        fs_ex = 1; ex_target = 32'h0040_0000; fs_allowin = 0;
        step("tlb_flush");
        fs_ex = 0; tlb_found = 0;
        #1;
        chk("tlbl.ex_type", 71'(bus[36:32]), 71'(5'h02));
        chk("tlbl.refill1", 71'(bus[70]), 71'(1));
        step("tlb_miss");
        tlb_found = 1; tlb_v = 0;
        #1;
        chk("tlbl.ex_type_inv", 71'(bus[36:32]), 71'(5'h02));
        chk("tlbl.refill0", 71'(bus[70]), 71'(0));
        step("tlb_inv");
        tlb_v = 1; tlb_pfn = 20'h00123; fs_allowin = 1; inst_cache_addr_ok = 0;
        #1;
        chk("tlb.hit_valid", 71'(inst_cache_valid), 71'(1));
        chk("tlb.hit_paddr", 71'(inst_cache_addr), 71'(32'h0012_3000));
        step("tlb_hit");

        // randomized traffic against the model
        idle();
        fs_ex = 1; ex_target = 32'hbfc0_0000;
        step("rnd_start");
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                reset = 1'b1;
                #1 chk("rnd.mid_reset", 71'({to_fs_valid, inst_cache_valid}), 71'(0));
                model_reset();
                @(negedge clk);
                reset = 1'b0;
            end
            fs_ex              = ($urandom_range(0, 15) == 0);
            ex_target          = rand_addr();
            fs_cancel_in       = ($urandom_range(0, 15) == 0);
            cancel_target      = rand_addr();
            br_valid           = ($urandom_range(0, 5) == 0);
            br_target          = rand_addr();
            br_stall           = ($urandom_range(0, 3) == 0);
            fs_allowin         = ($urandom_range(0, 3) != 0);
            inst_cache_addr_ok = ($urandom_range(0, 2) != 0);
            tlb_found          = ($urandom_range(0, 3) != 0);
            tlb_v              = ($urandom_range(0, 3) != 0);
            tlb_pfn            = 20'($urandom);
            step("rnd");
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
